// File: rtl/shwr_area_capture_pkg.sv
// shwr_area_capture_pkg: shared constants and FSM states for shower area capture
package shwr_area_capture_pkg;

    localparam int SHWR_AREA_BINS      = 20;
    localparam int SHWR_CAPTURE_DELAY  = SHWR_AREA_BINS + 2;
    localparam int SHWR_REC_DEPTH_LOG2 = 2;
    localparam int SHWR_REC_TAG_WIDTH  = 8;

    typedef enum logic [1:0] {IDLE, WINDOW, DONE} cap_state_t;

endpackage

// File: rtl/shwr_rec_fifo.sv
// shwr_rec_fifo: synchronous show-ahead FIFO; rd_data always presents the head entry
module shwr_rec_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  CLK120,
    input  logic                  RESET_N,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  rd_ok, wr_ok;

    assign empty   = count == '0;
    assign full    = count == (DEPTH_LOG2 + 1)'(DEPTH);
    assign rd_ok   = rd_en && !empty;
    // a pop in the same cycle frees the slot the write lands in
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (DEPTH_LOG2 + 1)'(wr_ok) - (DEPTH_LOG2 + 1)'(rd_ok);
        end
    end

endmodule

// File: rtl/shwr_area_capture.sv
// shwr_area_capture: snapshots the shower integral at window end (or early trigger drop)
// and queues tagged records for readout.
module shwr_area_capture
    import shwr_area_capture_pkg::*;
#(
    parameter int ADC_WIDTH  = 12,
    parameter int AREA_WIDTH = 19,
    parameter int FRAC_WIDTH = 6,
    parameter int AREA_BINS  = SHWR_AREA_BINS,
    parameter int DEPTH_LOG2 = SHWR_REC_DEPTH_LOG2
) (
    input  logic                             CLK120,
    input  logic                             RESET_N,
    input  logic                             TRIGGERED,
    input  logic [AREA_WIDTH+FRAC_WIDTH-1:0] INTEGRAL,
    input  logic [ADC_WIDTH-1:0]             PEAK,
    input  logic [ADC_WIDTH+FRAC_WIDTH-1:0]  BASELINE,
    input  logic                             SATURATED,
    input  logic                             RD_EN,
    output logic                             REC_VALID,
    output logic [AREA_WIDTH+FRAC_WIDTH-1:0] REC_INTEGRAL,
    output logic [ADC_WIDTH-1:0]             REC_PEAK,
    output logic [ADC_WIDTH-1:0]             REC_BASELINE,
    output logic [1:0]                       REC_FLAGS,
    output logic [SHWR_REC_TAG_WIDTH-1:0]    REC_TAG,
    output logic [DEPTH_LOG2:0]              REC_COUNT,
    output logic [7:0]                       OVERFLOW_COUNT
);

    localparam int IW            = AREA_WIDTH + FRAC_WIDTH;
    localparam int TW            = SHWR_REC_TAG_WIDTH;
    localparam int RW            = IW + 2 * ADC_WIDTH + 2 + TW;
    localparam int CAPTURE_DELAY = AREA_BINS + (SHWR_CAPTURE_DELAY - SHWR_AREA_BINS);
    localparam int CW            = $clog2(CAPTURE_DELAY + 1);

    cap_state_t    state, state_n;
    logic [CW-1:0] bin, bin_n;
    logic [TW-1:0] tag;
    logic [RW-1:0] rec;
    logic          trig_prev, capture, truncated, full, empty, drop, unused_frac;

    assign unused_frac = ^BASELINE[FRAC_WIDTH-1:0];
    assign drop        = capture && full && !RD_EN;
    assign REC_VALID   = !empty;
    assign {REC_INTEGRAL, REC_PEAK, REC_BASELINE, REC_FLAGS, REC_TAG} = rec;

    // trig_prev resets high so a trigger already asserted at reset release is not a rise
    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= IDLE;
            bin            <= '0;
            trig_prev      <= 1'b1;
            tag            <= '0;
            OVERFLOW_COUNT <= '0;
        end else begin
            state     <= state_n;
            bin       <= bin_n;
            trig_prev <= TRIGGERED;
            if (capture) tag <= tag + 1'b1;
            if (drop && OVERFLOW_COUNT != 8'hff) OVERFLOW_COUNT <= OVERFLOW_COUNT + 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        bin_n     = bin;
        capture   = 1'b0;
        truncated = 1'b0;
        case (state)
            IDLE: if (TRIGGERED && !trig_prev) begin
                state_n = WINDOW;
                bin_n   = '0;
            end
            WINDOW: if (!TRIGGERED) begin
                capture   = 1'b1;
                truncated = 1'b1;
                state_n   = IDLE;
            end else if (bin == CW'(CAPTURE_DELAY)) begin
                capture = 1'b1;
                state_n = DONE;
            end else begin
                bin_n = bin + 1'b1;
            end
            DONE: if (!TRIGGERED) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    shwr_rec_fifo #(
        .WIDTH      (RW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .CLK120  (CLK120),
        .RESET_N (RESET_N),
        .wr_en   (capture),
        .wr_data ({INTEGRAL, PEAK, BASELINE[ADC_WIDTH+FRAC_WIDTH-1:FRAC_WIDTH], truncated, SATURATED, tag}),
        .rd_en   (RD_EN),
        .rd_data (rec),
        .empty   (empty),
        .full    (full),
        .count   (REC_COUNT)
    );

endmodule

// File: tb/tb_shwr_area_capture.sv
// tb_shwr_area_capture: table vectors plus scoreboarded multi-cycle sequences for shwr_area_capture
module tb_shwr_area_capture;

    localparam int IW = 25, AW = 12, BW = 18;

    logic          CLK120 = 0, RESET_N = 0, TRIGGERED = 0, SATURATED = 0, RD_EN = 0;
    logic [IW-1:0] INTEGRAL = '0;
    logic [AW-1:0] PEAK = '0;
    logic [BW-1:0] BASELINE = '0;
    logic          REC_VALID;
    logic [IW-1:0] REC_INTEGRAL;
    logic [AW-1:0] REC_PEAK, REC_BASELINE;
    logic [1:0]    REC_FLAGS;
    logic [7:0]    REC_TAG, OVERFLOW_COUNT;
    logic [2:0]    REC_COUNT;

    int          n_pass = 0, n_total = 0, exp_tag = 0, exp_ovf = 0;
    logic [63:0] q[$];

    typedef struct {
        int            len;
        logic [IW-1:0] base;
        logic [AW-1:0] peak;
        logic [BW-1:0] bl;
        logic          sat;
        logic [IW-1:0] exp_int;
        logic [1:0]    exp_flags;
    } vec_t;
    vec_t vt[5];

    shwr_area_capture dut (
        .CLK120         (CLK120),
        .RESET_N        (RESET_N),
        .TRIGGERED      (TRIGGERED),
        .INTEGRAL       (INTEGRAL),
        .PEAK           (PEAK),
        .BASELINE       (BASELINE),
        .SATURATED      (SATURATED),
        .RD_EN          (RD_EN),
        .REC_VALID      (REC_VALID),
        .REC_INTEGRAL   (REC_INTEGRAL),
        .REC_PEAK       (REC_PEAK),
        .REC_BASELINE   (REC_BASELINE),
        .REC_FLAGS      (REC_FLAGS),
        .REC_TAG        (REC_TAG),
        .REC_COUNT      (REC_COUNT),
        .OVERFLOW_COUNT (OVERFLOW_COUNT)
    );

    always #5 CLK120 = ~CLK120;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK120);
        #1;
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] rec(logic [IW-1:0] i, logic [AW-1:0] p, logic [BW-1:0] b,
                                        logic [1:0] f, int t);
        return {5'd0, i, p, b[BW-1:6], f, t[7:0]};
    endfunction

    function automatic logic [63:0] head();
        return {5'd0, REC_INTEGRAL, REC_PEAK, REC_BASELINE, REC_FLAGS, REC_TAG};
    endfunction

    // full-length windows capture INTEGRAL 23 cycles after the rise; short ones on the first low cycle
    task automatic expect_event(int len, logic [IW-1:0] base, logic [AW-1:0] p, logic [BW-1:0] b, logic s);
        logic          tr;
        logic [IW-1:0] v;
        tr = len < 24;
        v  = base + IW'(tr ? len : 23);
        if (q.size() < 4) q.push_back(rec(v, p, b, {tr, s}, exp_tag));
        else exp_ovf++;
        exp_tag = (exp_tag + 1) % 256;
    endtask

    task automatic pulse(int len, int gap, logic [IW-1:0] base, logic [AW-1:0] p, logic [BW-1:0] b, logic s);
        PEAK = p; BASELINE = b; SATURATED = s;
        for (int i = 0; i < len; i++) begin
            TRIGGERED = 1; INTEGRAL = base + IW'(i); step();
        end
        TRIGGERED = 0; INTEGRAL = base + IW'(len); step();
        for (int i = 1; i < gap; i++) step();
    endtask

    task automatic pop_check(string name);
        logic [63:0] e;
        e = q.size() != 0 ? q.pop_front() : '1;
        check({name, " valid"}, 64'(REC_VALID), 64'd1);
        check({name, " record"}, head(), e);
        RD_EN = 1; step(); RD_EN = 0;
    endtask

    task automatic do_reset();
        TRIGGERED = 0; RD_EN = 0; RESET_N = 0;
        step(); step();
        RESET_N = 1;
        step();
        q.delete(); exp_tag = 0; exp_ovf = 0;
    endtask

    initial begin
        vt[0] = '{5,  25'h0000100, 12'h0a5, 18'h0abc0, 1'b0, 25'h0000105, 2'b10};
        vt[1] = '{1,  25'h0001000, 12'hfff, 18'h3ffff, 1'b1, 25'h0001001, 2'b11};
        vt[2] = '{23, 25'h0002000, 12'h123, 18'h12345, 1'b0, 25'h0002017, 2'b10};
        vt[3] = '{24, 25'h0003000, 12'h456, 18'h23456, 1'b1, 25'h0003017, 2'b01};
        vt[4] = '{30, 25'h1ffff00, 12'h800, 18'h20000, 1'b0, 25'h1ffff17, 2'b00};

        step();
        check("reset valid", 64'(REC_VALID), 0);
        check("reset count", 64'(REC_COUNT), 0);
        check("reset overflow", 64'(OVERFLOW_COUNT), 0);
        check("reset record", head(), 0);
        RESET_N = 1; step();

        // single event, RD_EN held during capture into the empty buffer
        PEAK = 12'h7ab; BASELINE = 18'h0c840; SATURATED = 0; INTEGRAL = '0; TRIGGERED = 1; step();
        for (int i = 1; i <= 22; i++) begin
            if (i == 22) INTEGRAL = 25'h12340;
            step();
        end
        check("valid before capture", 64'(REC_VALID), 0);
        RD_EN = 1; step(); RD_EN = 0;
        check("valid after capture", 64'(REC_VALID), 1);
        check("count empty pop+capture", 64'(REC_COUNT), 1);
        check("single record", head(), rec(25'h12340, 12'h7ab, 18'h0c840, 2'b00, 0));
        for (int i = 24; i < 40; i++) step();
        TRIGGERED = 0; step(); step();
        check("no extended capture", 64'(REC_COUNT), 1);
        RD_EN = 1; step(); RD_EN = 0;
        check("empty after pop", 64'(REC_VALID), 0);
        exp_tag = 1;

        foreach (vt[k]) begin
            q.push_back(rec(vt[k].exp_int, vt[k].peak, vt[k].bl, vt[k].exp_flags, exp_tag));
            exp_tag++;
            pulse(vt[k].len, 3, vt[k].base, vt[k].peak, vt[k].bl, vt[k].sat);
            pop_check($sformatf("vec%0d", k));
        end

        // reset in the middle of a window, trigger held high across release
        do_reset();
        expect_event(30, 25'h00777, 12'h111, 18'h04440, 0);
        pulse(30, 3, 25'h00777, 12'h111, 18'h04440, 0);
        check("pre-reset valid", 64'(REC_VALID), 1);
        TRIGGERED = 1; step();
        for (int i = 1; i <= 11; i++) step();
        #2 RESET_N = 0;
        #1;
        check("async reset valid", 64'(REC_VALID), 0);
        check("async reset count", 64'(REC_COUNT), 0);
        check("async reset record", head(), 0);
        q.delete(); exp_tag = 0;
        step(); step();
        RESET_N = 1;
        for (int i = 0; i < 40; i++) step();
        check("no capture while held", 64'(REC_COUNT), 0);
        TRIGGERED = 0; step(); step();
        check("no capture on drop", 64'(REC_COUNT), 0);
        expect_event(30, 25'h00888, 12'h222, 18'h08880, 1);
        pulse(30, 3, 25'h00888, 12'h222, 18'h08880, 1);
        pop_check("rearm");

        // six events without reads
        do_reset();
        for (int e = 0; e < 6; e++) begin
            expect_event(30, 25'h10000 + IW'(e * 256), AW'(e + 1), BW'(e * 64), e[0]);
            pulse(30, 3, 25'h10000 + IW'(e * 256), AW'(e + 1), BW'(e * 64), e[0]);
        end
        check("overflow count", 64'(OVERFLOW_COUNT), 64'(exp_ovf));
        check("overflow rec count", 64'(REC_COUNT), 4);
        for (int i = 0; i < 4; i++) pop_check($sformatf("ovf pop%0d", i));
        check("overflow drained", 64'(REC_VALID), 0);

        // full buffer, pop and capture in the same cycle
        do_reset();
        for (int e = 0; e < 4; e++) begin
            expect_event(30, 25'h20000 + IW'(e), AW'(e), BW'(e * 128), 0);
            pulse(30, 3, 25'h20000 + IW'(e), AW'(e), BW'(e * 128), 0);
        end
        PEAK = 12'h5a5; BASELINE = 18'h15a40; SATURATED = 1; INTEGRAL = 25'h0abcd; TRIGGERED = 1; step();
        for (int i = 1; i <= 22; i++) step();
        check("full count", 64'(REC_COUNT), 4);
        check("full head", head(), q[0]);
        RD_EN = 1; step(); RD_EN = 0;
        void'(q.pop_front());
        q.push_back(rec(25'h0abcd, 12'h5a5, 18'h15a40, 2'b01, exp_tag));
        exp_tag++;
        check("full pop+capture overflow", 64'(OVERFLOW_COUNT), 0);
        check("full pop+capture count", 64'(REC_COUNT), 4);
        TRIGGERED = 0; step(); step();
        for (int i = 0; i < 4; i++) pop_check($sformatf("full pop%0d", i));

        // back-to-back pulses separated by a single low cycle
        do_reset();
        expect_event(30, 25'h00a00, 12'h0aa, 18'h02a80, 0);
        pulse(30, 1, 25'h00a00, 12'h0aa, 18'h02a80, 0);
        expect_event(30, 25'h00b00, 12'h0bb, 18'h02ec0, 1);
        pulse(30, 3, 25'h00b00, 12'h0bb, 18'h02ec0, 1);
        check("b2b count", 64'(REC_COUNT), 2);
        pop_check("b2b first");
        pop_check("b2b second");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
